// File: rtl/ul_seq.sv
// ul_seq: registered W-bit AND/OR/XOR/NOT unit with accumulator and DEPTH-entry result FIFO.
// Latency 1 cycle into an empty FIFO; in_ready depends on occupancy only. Optional `par` output under UL_SEQ_PARITY_EN.
module ul_seq #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   s,
    input  logic         acc_sel,
    input  logic         acc_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         zero
`ifdef UL_SEQ_PARITY_EN
    ,
    output logic         par
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]     acc;
    logic [W-1:0]     opa;
    logic [W-1:0]     result;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             accept;
    logic             pop;

    logic [W-1:0]     res_mem [DEPTH];
    logic [DEPTH-1:0] zero_mem;
`ifdef UL_SEQ_PARITY_EN
    logic [DEPTH-1:0] par_mem;
`endif

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign opa       = acc_sel ? acc : a;

    always_comb begin
        result = '0;
        case (s)
            2'b00:   result = opa & b;
            2'b01:   result = opa | b;
            2'b10:   result = opa ^ b;
            default: result = ~opa;
        endcase
    end

    // Storage needs no reset: the head is masked to zero whenever count is zero.
    always_ff @(posedge clk) begin
        if (accept) begin
            res_mem[wr_ptr]  <= result;
            zero_mem[wr_ptr] <= (result == '0);
`ifdef UL_SEQ_PARITY_EN
            par_mem[wr_ptr]  <= ^result;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Clear wins over the accumulate, but the op still used the old acc.
            if (acc_clr) begin
                acc <= '0;
            end else if (accept) begin
                acc <= result;
            end
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign out  = out_valid ? res_mem[rd_ptr] : '0;
    assign zero = out_valid ? zero_mem[rd_ptr] : 1'b0;
`ifdef UL_SEQ_PARITY_EN
    assign par  = out_valid ? par_mem[rd_ptr] : 1'b0;
`endif

endmodule

// File: doc/ul_seq.md
Name: ul_seq

Overview:
- Parametrised, registered successor of the 4-bit combinational logic unit.
- Computes W-bit AND/OR/XOR/NOT on operands `a`/`b`, selected by the 2-bit `s`, as in the 4-bit unit.
- Adds an accumulator mode, where the previous result replaces `a`.
- Uses a valid/ready input handshake and a DEPTH-entry result FIFO with valid/ready output handshake.
- Sits between operand producers and the datapath consumer in the practice designs.

Parameters:
- W, 4: operand/result width in bits; W >= 1.
- DEPTH, 2: result FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  operation request.
- in_ready  output  1  FIFO can accept an operation.
- a  input  W  operand A.
- b  input  W  operand B.
- s  input  2  operation select.
- acc_sel  input  1  1: use accumulator as operand A instead of `a`.
- acc_clr  input  1  synchronous accumulator clear.
- out_valid  output  1  head FIFO entry valid.
- out_ready  input  1  consumer takes the head entry.
- out  output  W  head result.
- zero  output  1  head result == 0.

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous, active-low, single clock domain.
- Reset values (immediately on rst_n=0, independent of clk):
  - count=0, pointers=0, acc=0.
  - out_valid=0, out=0, zero=0, in_ready=1.
- accept = in_valid & in_ready.
- pop = out_valid & out_ready.
- Operand A = acc_sel ? acc : a.
- s encoding:
  - 00: A & b
  - 01: A | b
  - 10: A ^ b
  - 11: ~A (b ignored)
- Result is exactly W bits; no carry or extension.
- On accept: result and zero flag are written to FIFO at wr_ptr, wr_ptr increments, and acc <= result.
- acc_clr=1: acc <= 0 at the edge, with priority over the accept update. An op accepted in the same cycle still uses the pre-clear acc value, and its result is still pushed.
- Latency: operation accepted at edge k -> out_valid=1 and out=result after edge k, when the FIFO was empty. Otherwise the result queues behind earlier entries in strict order.
- in_ready = (count != DEPTH).
  - Registered/derived from count only; no combinational path from out_ready.
  - When full, no accept occurs even if pop=1 in that cycle.
- out_valid = (count != 0).
- out and zero show the head entry when out_valid=1, and are forced to 0 when out_valid=0.
- Count update:
  - push and pop in the same cycle: count unchanged, both pointers advance.
  - push only: count+1.
  - pop only: count-1.
- Pointers wrap modulo DEPTH.
- Inputs are ignored when in_valid=0. The head entry holds stable while out_valid=1 and out_ready=0.
- Reset mid-operation: all queued entries and acc are discarded. An accept in flight at the reset assertion is lost.

Optional Feature:
- Macro: UL_SEQ_PARITY_EN.
- When defined:
  - Extra output port `par` (1 bit) = XOR-reduction of the head result, stored per FIFO entry.
  - `par` is 0 when out_valid=0 and on reset.
- When undefined: port `par` and its storage are absent; all other behaviour is identical.

Test Plan (W=4, DEPTH=2 unless stated):
1. Reset: assert rst_n=0 mid-clock -> out_valid=0, out=0000, zero=0, in_ready=1 immediately. Release, idle 3 cycles -> outputs unchanged.
2. out_ready=1, a=0101, b=1010, acc_sel=0, one op per cycle with s=00, 01, 10, 11 -> results appear one cycle after each accept:
   - s=00: 0000 (zero=1)
   - s=01: 1111
   - s=10: 1111
   - s=11: 1010
3. Backpressure: out_ready=0, in_valid held with ops s=00, 01, 10 -> two accepts, then in_ready=0 and the third op is held. Raise out_ready -> outputs 0000, 1111, 1111 in order, no loss or duplication.
4. Accumulator: pulse acc_clr, then acc_sel=1:
   - s=01, b=0011 -> 0011
   - s=10, b=0101 -> 0110
   - s=11 -> 1001
   - acc_clr together with s=01, b=0001 -> result 1001, acc=0 afterwards.
5. Simultaneous push/pop at count=1 -> count stays 1, in_ready=1, order preserved. Also cover the full case with pop and in_valid together -> pop only, count drops to 1.
6. Queue two entries with out_ready=0, then pulse rst_n low -> out_valid=0 asynchronously. After release, first accept with acc_sel=1, s=01, b=0000 -> out=0000 (acc was cleared).
